tempo_scheduler: RTL

TEMPO_SCHEDULER -- requirements
Module: tempo_scheduler

---
 rtl/tempo_scheduler.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/tempo_scheduler.sv
// rtl/tempo_scheduler.sv - beat/level/miss game scheduler driving an enable generator.
// Optional consecutive-miss level backoff is built when TEMPO_BACKOFF_EN is defined.
module tempo_scheduler #(
  parameter int BEATS_PER_LEVEL = 64,
  parameter int MISS_LIMIT      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       tick,
  input  logic       hit,
  input  logic       miss,
  output logic [9:0] speed,
  output logic       en_reset,
  output logic [2:0] level,
  output logic       running,
  output logic       paused,
  output logic       game_over,
  output logic       cleared,
  output logic       level_up,
  output logic       level_down
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam logic [7:0] BEAT_LAST = 8'(BEATS_PER_LEVEL - 1);
  localparam logic [7:0] MISS_LAST = 8'(MISS_LIMIT - 1);
  localparam logic [7:0] MISS_MAX  = 8'(MISS_LIMIT);

  state_t     state, state_nxt;
  logic [7:0] beat_cnt, beat_nxt;
  logic [7:0] miss_cnt, miss_nxt;
  logic [2:0] level_nxt;
  logic       game_over_nxt, cleared_nxt, level_up_nxt;
  logic       end_miss, end_clear;

`ifdef TEMPO_BACKOFF_EN
  logic [1:0] streak, streak_nxt;
  logic       level_down_r, level_down_nxt;
  assign level_down = level_down_r;
`else
  logic unused_hit;
  assign unused_hit = hit;
  assign level_down = 1'b0;
`endif

  function automatic logic [9:0] speed_of(input logic [2:0] lv);
    case (lv)
      3'd0:    speed_of = 10'd992;
      3'd1:    speed_of = 10'd960;
      3'd2:    speed_of = 10'd896;
      3'd3:    speed_of = 10'd768;
      default: speed_of = 10'd512;
    endcase
  endfunction

  always_comb begin
    state_nxt     = state;
    beat_nxt      = beat_cnt;
    miss_nxt      = miss_cnt;
    level_nxt     = level;
    game_over_nxt = game_over;
    cleared_nxt   = cleared;
    level_up_nxt  = 1'b0;
    end_miss      = 1'b0;
    end_clear     = 1'b0;
`ifdef TEMPO_BACKOFF_EN
    streak_nxt     = streak;
    level_down_nxt = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt     = RUN;
          beat_nxt      = 8'd0;
          miss_nxt      = 8'd0;
          level_nxt     = 3'd0;
          game_over_nxt = 1'b0;
          cleared_nxt   = 1'b0;
`ifdef TEMPO_BACKOFF_EN
          streak_nxt    = 2'd0;
`endif
        end
      end
      RUN: begin
        if (tick) begin
          if (beat_cnt == BEAT_LAST) begin
            beat_nxt = 8'd0;
            if (level < 3'd4) begin
              level_nxt    = level + 3'd1;
              level_up_nxt = 1'b1;
            end else begin
              end_clear = 1'b1;
            end
          end else begin
            beat_nxt = beat_cnt + 8'd1;
          end
        end
        // Miss wins over hit; the limit-reaching miss goes to DONE rather than backing off.
        if (miss) begin
          if (miss_cnt >= MISS_LAST) begin
            miss_nxt = MISS_MAX;
            end_miss = 1'b1;
          end else begin
            miss_nxt = miss_cnt + 8'd1;
`ifdef TEMPO_BACKOFF_EN
            if (streak == 2'd2) begin
              streak_nxt = 2'd0;
              if (level_nxt > 3'd0) begin
                level_nxt      = level_nxt - 3'd1;
                beat_nxt       = 8'd0;
                level_up_nxt   = 1'b0;
                level_down_nxt = 1'b1;
                end_clear      = 1'b0;
              end
            end else begin
              streak_nxt = streak + 2'd1;
            end
`endif
          end
        end
`ifdef TEMPO_BACKOFF_EN
        else if (hit) begin
          streak_nxt = 2'd0;
        end
`endif
        if (end_miss) begin
          state_nxt     = DONE;
          game_over_nxt = 1'b1;
        end else if (end_clear) begin
          state_nxt   = DONE;
          cleared_nxt = 1'b1;
        end else if (pause) begin
          state_nxt = PAUSE;
        end
      end
      PAUSE: begin
        if (!pause) state_nxt = RUN;
      end
      DONE: begin
        if (start) begin
          state_nxt     = IDLE;
          game_over_nxt = 1'b0;
          cleared_nxt   = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      beat_cnt  <= 8'd0;
      miss_cnt  <= 8'd0;
      level     <= 3'd0;
      speed     <= 10'd992;
      paused    <= 1'b0;
      game_over <= 1'b0;
      cleared   <= 1'b0;
      level_up  <= 1'b0;
`ifdef TEMPO_BACKOFF_EN
      streak       <= 2'd0;
      level_down_r <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      beat_cnt  <= beat_nxt;
      miss_cnt  <= miss_nxt;
      level     <= level_nxt;
      speed     <= speed_of(level_nxt);
      paused    <= (state_nxt == PAUSE);
      game_over <= game_over_nxt;
      cleared   <= cleared_nxt;
      level_up  <= level_up_nxt;
`ifdef TEMPO_BACKOFF_EN
      streak       <= streak_nxt;
      level_down_r <= level_down_nxt;
`endif
    end
  end

  assign running  = (state == RUN);
  assign en_reset = (state != RUN);

endmodule
